// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI-Lite write arbiter.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_RESP   = 3'd3,
    ST_SRESP  = 3'd4
  } arb_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // Grant index width for the supported 2..4 requester range.
  function automatic int idx_width(input int n);
    return (n > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: the search starts one past the last granted port.
module rr_arbiter #(
  parameter int S_COUNT = 2,
  parameter int IDX_W   = 1
) (
  input  logic [S_COUNT-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [S_COUNT-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    for (int off = 1; off <= S_COUNT; off++) begin
      w_idx = IDX_W'((int'(i_last_grant) + off) % S_COUNT);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/axil_wr_arb.sv
// S_COUNT-to-1 AXI-Lite write arbiter with a single outstanding write.
//   state  | meaning
//   IDLE   | wait for any port with both AW and W valid, pick round-robin
//   ACCEPT | one-cycle AW/W handshake with the granted port, latch payload
//   ISSUE  | drive AW and W on the master port until both handshakes finish
//   RESP   | wait for master B response
//   SRESP  | forward B response to the granted port
module axil_wr_arb
  import axil_arb_pkg::*;
#(
  parameter int S_COUNT    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [S_COUNT*ADDR_WIDTH-1:0]  s_axil_awaddr,
  input  logic [S_COUNT*3-1:0]           s_axil_awprot,
  input  logic [S_COUNT-1:0]             s_axil_awvalid,
  output logic [S_COUNT-1:0]             s_axil_awready,
  input  logic [S_COUNT*DATA_WIDTH-1:0]  s_axil_wdata,
  input  logic [S_COUNT*STRB_WIDTH-1:0]  s_axil_wstrb,
  input  logic [S_COUNT-1:0]             s_axil_wvalid,
  output logic [S_COUNT-1:0]             s_axil_wready,
  output logic [S_COUNT*2-1:0]           s_axil_bresp,
  output logic [S_COUNT-1:0]             s_axil_bvalid,
  input  logic [S_COUNT-1:0]             s_axil_bready,
  output logic [ADDR_WIDTH-1:0]          m_axil_awaddr,
  output logic [2:0]                     m_axil_awprot,
  output logic                           m_axil_awvalid,
  input  logic                           m_axil_awready,
  output logic [DATA_WIDTH-1:0]          m_axil_wdata,
  output logic [STRB_WIDTH-1:0]          m_axil_wstrb,
  output logic                           m_axil_wvalid,
  input  logic                           m_axil_wready,
  input  logic [1:0]                     m_axil_bresp,
  input  logic                           m_axil_bvalid,
  output logic                           m_axil_bready
);

  localparam int IDX_W = idx_width(S_COUNT);

  arb_state_t r_state, w_state_nxt;

  logic [S_COUNT-1:0]    w_req;
  logic [S_COUNT-1:0]    w_arb_oh;
  logic [IDX_W-1:0]      w_arb_idx;
  logic                  w_aw_done;
  logic                  w_w_done;
  logic                  w_s_bhs;

  logic [IDX_W-1:0]      r_grant;
  logic [S_COUNT-1:0]    r_grant_oh;
  logic [IDX_W-1:0]      r_last_grant;
  logic                  r_m_awvalid;
  logic                  r_m_wvalid;
  logic [1:0]            r_bresp;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [2:0]            r_awprot;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;

  assign w_req     = s_axil_awvalid & s_axil_wvalid;
  assign w_aw_done = !r_m_awvalid || m_axil_awready;
  assign w_w_done  = !r_m_wvalid || m_axil_wready;
  assign w_s_bhs   = |(s_axil_bready & r_grant_oh);

  rr_arbiter #(
    .S_COUNT (S_COUNT),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_arb_oh),
    .o_grant_idx  (w_arb_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    s_axil_awready = '0;
    s_axil_wready  = '0;
    s_axil_bvalid  = '0;
    s_axil_bresp   = '0;
    m_axil_bready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) w_state_nxt = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        s_axil_awready = r_grant_oh;
        s_axil_wready  = r_grant_oh;
        w_state_nxt    = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_aw_done && w_w_done) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        m_axil_bready = 1'b1;
        if (m_axil_bvalid) w_state_nxt = ST_SRESP;
      end
      ST_SRESP: begin
        s_axil_bvalid = r_grant_oh;
        for (int i = 0; i < S_COUNT; i++) begin
          if (r_grant_oh[i]) s_axil_bresp[2*i +: 2] = r_bresp;
        end
        if (w_s_bhs) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant      <= '0;
      r_grant_oh   <= '0;
      r_last_grant <= IDX_W'(S_COUNT - 1);
      r_m_awvalid  <= 1'b0;
      r_m_wvalid   <= 1'b0;
      r_bresp      <= OKAY;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_grant    <= w_arb_idx;
            r_grant_oh <= w_arb_oh;
          end
        end
        ST_ACCEPT: begin
          r_m_awvalid <= 1'b1;
          r_m_wvalid  <= 1'b1;
        end
        ST_ISSUE: begin
          if (m_axil_awready) r_m_awvalid <= 1'b0;
          if (m_axil_wready)  r_m_wvalid  <= 1'b0;
        end
        ST_RESP: begin
          if (m_axil_bvalid) r_bresp <= m_axil_bresp;
        end
        ST_SRESP: begin
          if (w_s_bhs) r_last_grant <= r_grant;
        end
        default: ;
      endcase
    end
  end

  // Payload is only observed while the master valids are set, so no reset.
  always_ff @(posedge clk) begin
    if (r_state == ST_ACCEPT) begin
      r_awaddr <= s_axil_awaddr[int'(r_grant)*ADDR_WIDTH +: ADDR_WIDTH];
      r_awprot <= s_axil_awprot[int'(r_grant)*3 +: 3];
      r_wdata  <= s_axil_wdata[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
      r_wstrb  <= s_axil_wstrb[int'(r_grant)*STRB_WIDTH +: STRB_WIDTH];
    end
  end

  assign m_axil_awaddr  = r_awaddr;
  assign m_axil_awprot  = r_awprot;
  assign m_axil_awvalid = r_m_awvalid;
  assign m_axil_wdata   = r_wdata;
  assign m_axil_wstrb   = r_wstrb;
  assign m_axil_wvalid  = r_m_wvalid;

endmodule

// File: doc/axil_wr_arb.md
AXIL_WR_ARB -- requirements
Module: axil_wr_arb

Interface
REQ-001 SHALL have parameter S_COUNT, default 2, number of slave (requester) ports, legal range 2..4.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, address bus width in bits.
REQ-004 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, strobe width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have s_axil_awaddr/awprot/awvalid, input, S_COUNT*ADDR_WIDTH / S_COUNT*3 / S_COUNT; port i occupies slice i.
REQ-008 SHALL have s_axil_awready, output, S_COUNT, per-port AW ready.
REQ-009 SHALL have s_axil_wdata/wstrb/wvalid, input, S_COUNT*DATA_WIDTH / S_COUNT*STRB_WIDTH / S_COUNT.
REQ-010 SHALL have s_axil_wready, output, S_COUNT, per-port W ready.
REQ-011 SHALL have s_axil_bresp/bvalid, output, S_COUNT*2 / S_COUNT; s_axil_bready, input, S_COUNT.
REQ-012 SHALL have m_axil_awaddr/awprot/awvalid, output, ADDR_WIDTH/3/1; m_axil_awready, input, 1.
REQ-013 SHALL have m_axil_wdata/wstrb/wvalid, output, DATA_WIDTH/STRB_WIDTH/1; m_axil_wready, input, 1.
REQ-014 SHALL have m_axil_bresp/bvalid, input, 2/1; m_axil_bready, output, 1.

Function
REQ-015 SHALL consider port i requesting only when s_axil_awvalid[i] and s_axil_wvalid[i] are both high; AW-only or W-only is not a request.
REQ-016 SHALL carry at most one write outstanding on the master port.
REQ-017 SHALL implement states IDLE, ACCEPT, ISSUE, RESP, SRESP.
REQ-018 IDLE: on any request, select winner round-robin, starting at index (last_grant+1) mod S_COUNT, register grant index, and go to ACCEPT.
REQ-019 ACCEPT (exactly one cycle): assert s_axil_awready[g] and s_axil_wready[g] only; capture AW and W payload of port g; go to ISSUE.
REQ-020 ISSUE: m_axil_awvalid and m_axil_wvalid rise the cycle after ACCEPT; each drops independently after its own handshake; both payloads are held stable while valid.
REQ-021 ISSUE: when both handshakes are complete, including both in the same cycle, go to RESP.
REQ-022 RESP: m_axil_bready=1 only in RESP; on m_axil_bvalid, capture m_axil_bresp and go to SRESP.
REQ-023 SRESP: assert s_axil_bvalid[g] with the captured bresp; on s_axil_bready[g], set last_grant=g and go to IDLE.
REQ-024 All ready/valid outputs of non-granted ports SHALL be 0 at all times.
REQ-025 Minimum latency SHALL be: request at cycle 0, ready at cycle 1, m valids at cycle 2.
REQ-026 With zero-wait master and slave, one complete write SHALL take 5 cycles, IDLE to IDLE.
REQ-027 Requests arriving or withdrawn in states other than IDLE SHALL not affect the current transaction.
REQ-028 m_axil_bvalid outside RESP SHALL be ignored; m_axil_bready stays 0.
REQ-029 All outputs SHALL be driven from registers or from the registered state/grant only; there is no combinational path from s_* inputs to m_* outputs.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, last_grant=S_COUNT-1 (so port 0 wins first), and all outputs low: every valid, every ready, and m_axil_bready.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction with no response generated; after release, operation restarts from IDLE.
REQ-032 Payload registers SHALL require no reset.

Structure
REQ-033 Package axil_arb_pkg SHALL hold the state encoding and the AXI resp constants OKAY=2'b00 and SLVERR=2'b10.
REQ-034 Round-robin selection SHALL be the sub-module rr_arbiter, with inputs req[S_COUNT] and last grant, and outputs one-hot grant and grant index.

Verification
REQ-035 Single request: port 1 writes addr 0x10, data 0xA5A5A5A5, strb 0xF, master bresp=OKAY -> master sees the same values, s_axil_bresp[1]=00, 5-cycle transaction.
REQ-036 Contention: ports 0 and 1 both request continuously for 4 transactions after reset -> grant order 0,1,0,1.
REQ-037 Split handshake: m_axil_awready at ISSUE+0, m_axil_wready at ISSUE+3 -> awvalid drops after cycle 0, wvalid held 4 cycles, RESP entered after the W handshake.
REQ-038 Error propagation: master returns bresp=2'b10 and port 0 holds s_axil_bready=0 for 3 cycles -> s_axil_bvalid[0] held with 2'b10, no new grant until the handshake.
REQ-039 Partial request: port 0 awvalid=1 with wvalid=0 while port 1 fully requests -> port 1 granted, port 0 awready stays 0.
REQ-040 Reset in ISSUE: drop rst_n -> m_axil_awvalid and m_axil_wvalid go 0 asynchronously; after release, the next grant goes to port 0.
